// File: rtl/div_req_dispatch.sv
// rtl/div_req_dispatch.sv - queues division requests and dispatches them one at a time to a radix-2 divider
module div_req_dispatch #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_dividend,
    input  logic [7:0]      in_divisor,
    input  logic            in_sign,
    input  logic [TAGW-1:0] in_tag,
    output logic            div_opn_valid,
    output logic [7:0]      div_dividend,
    output logic [7:0]      div_divisor,
    output logic            div_sign,
    input  logic            div_res_valid,
    output logic            div_res_ready,
    input  logic [15:0]     div_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_quotient,
    output logic [7:0]      out_remainder,
    output logic [TAGW-1:0] out_tag,
    output logic            out_dbz
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 17 + TAGW;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [TAGW-1:0] tag_q;

    logic            push;
    logic            pop;
    logic [7:0]      head_dividend;
    logic [7:0]      head_divisor;
    logic            head_sign;
    logic [TAGW-1:0] head_tag;

    assign {head_dividend, head_divisor, head_sign, head_tag} = mem[rd_ptr];

    // No pop credit when full: in_ready depends on count alone.
    assign in_ready      = (count < (AW+1)'(DEPTH));
    assign push          = in_valid && in_ready;
    assign pop           = (state == IDLE) && (count != '0) && !out_valid;
    assign div_res_ready = (state == WAIT) && !out_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_dividend, in_divisor, in_sign, in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            tag_q         <= '0;
            div_opn_valid <= 1'b0;
            div_dividend  <= 8'd0;
            div_divisor   <= 8'd0;
            div_sign      <= 1'b0;
            out_valid     <= 1'b0;
            out_quotient  <= 8'd0;
            out_remainder <= 8'd0;
            out_tag       <= '0;
            out_dbz       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        div_dividend <= head_dividend;
                        div_divisor  <= head_divisor;
                        div_sign     <= head_sign;
                        tag_q        <= head_tag;
                        // Divide-by-zero never reaches the divider.
                        if (head_divisor == 8'd0) begin
                            out_valid     <= 1'b1;
                            out_quotient  <= 8'hFF;
                            out_remainder <= head_dividend;
                            out_tag       <= head_tag;
                            out_dbz       <= 1'b1;
                        end else begin
                            div_opn_valid <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    div_opn_valid <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (div_res_valid && div_res_ready) begin
                        out_valid     <= 1'b1;
                        out_quotient  <= div_result[7:0];
                        out_remainder <= div_result[15:8];
                        out_tag       <= tag_q;
                        out_dbz       <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
